id_ex_issue: RTL
================

# id_ex_issue

ID/EX pipeline stage directly upstream of the ALU. Registers decoded operands and controls, resolves RAW hazards by forwarding from EX/MEM and MEM/WB, and drives the ALU's operandA, operandB and operation inputs. Detects load-use hazards, requests an upstream stall, and inserts a bubble. Supports downstream stall (hold) and branch/exception flush.
## Interface
- WIDTH, 32, datapath width
- REGBITS, 5, register index width
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- stall  in  1  downstream hold; stage keeps its contents
- flush  in  1  squash the instruction entering this stage
- id_valid  in  1  decode slot holds a real instruction
- id_rs  in  REGBITS  source register A index
- id_rt  in  REGBITS  source register B index
- id_rd  in  REGBITS  resolved destination index
- id_rs_data  in  WIDTH  register file read A
- id_rt_data  in  WIDTH  register file read B
- id_imm  in  WIDTH  sign/zero-extended immediate
- id_alu_op  in  4  ALU code: 0000 and, 0001 or, 0010 add, 0110 sub, 0111 slt, 1100 nor
- id_ctrl  in  6  [5] reg_write, [4] mem_read, [3] mem_write, [2] mem_to_reg, [1] alu_src (1 = immediate), [0] uses_rt
- exmem_reg_write  in  1  EX/MEM instruction writes a register
- exmem_rd  in  REGBITS  EX/MEM destination
- exmem_result  in  WIDTH  EX/MEM ALU result
- memwb_reg_write  in  1  MEM/WB instruction writes a register
- memwb_rd  in  REGBITS  MEM/WB destination
- memwb_data  in  WIDTH  MEM/WB writeback value
- hazard_stall  out  1  combinational; PC and IF/ID must hold
- ex_valid  out  1  EX slot holds a real instruction
- operandA  out  WIDTH  to ALU
- operandB  out  WIDTH  to ALU
- operation  out  4  to ALU
- ex_store_data  out  WIDTH  forwarded rt value for stores
- ex_rd  out  REGBITS  destination carried to EX/MEM
- ex_ctrl  out  4  {reg_write, mem_read, mem_write, mem_to_reg}, all 0 when ex_valid=0
## Operation
- Registered state: valid, rs, rt, rd, rs_data, rt_data, imm, alu_op, ctrl. On reset, all fields are 0; therefore ex_valid=0, operation=0000, ex_ctrl=0, and ex_rd=0.
- Edge priority: flush → bubble; else stall → hold all fields; else hazard_stall → bubble; else load from id_*.
- A bubble sets valid=0 and ctrl=0. Data fields are don't-care but must not produce writes.
- Forwarded A = exmem_result if exmem_reg_write && exmem_rd==rs && rs!=0; else memwb_data if memwb_reg_write && memwb_rd==rs && rs!=0; else rs_data. Forwarded B is the same, using rt. EX/MEM beats MEM/WB.
- operandA = forwarded A. operandB = imm if alu_src, else forwarded B. ex_store_data = forwarded B always. operation = registered alu_op.
- hazard_stall = id_valid && ex_valid && ex mem_read && ex_rd!=0 && (ex_rd==id_rs || (id_ctrl[0] && ex_rd==id_rt)).
- Register $0 is never a forwarding source or a hazard source.
## Timing
- Latency 1 cycle from id_* capture to ALU inputs. Forwarding muxes and hazard_stall are combinational on current inputs and state.
- A load-use case costs exactly 1 bubble. On the next cycle the load is in EX/MEM, the hazard clears, and the consumer forwards from MEM/WB.
- While stall=1, the outputs stay stable except for the forwarding-mux results, which track the exmem/memwb inputs.
- Reset asserted mid-operation clears the state immediately, without waiting for a clock edge. The first capture happens on the first edge after deassertion.
## Configuration
- ID_EX_FORWARD_EN defined: forwarding muxes are active as described.
- ID_EX_FORWARD_EN undefined: operands come straight from registered data. hazard_stall additionally asserts on any RAW hazard (rs, or rt when uses_rt, nonzero) against the EX instruction with reg_write, or against exmem_rd with exmem_reg_write. MEM/WB needs no stall because the register file writes before it reads.
## Test plan
- Reset pulse mid-stream → ex_valid=0, ex_ctrl=0, operation=0000 asynchronously; id_rs_data=5, id_rt_data=7, alu_op=0010 next edge → operandA=5, operandB=7, operation=0010.
- EX/MEM writes $3=0x10 and MEM/WB writes $3=0x20, consumer rs=3 → operandA=0x10; same with rd=0 → operandA=id_rs_data.
- lw $4 in EX, then add using $4 as rt → hazard_stall=1 for one cycle, bubble (ex_valid=0), then operandB=memwb_data.
- stall=1 for 3 cycles with new id_* → registered fields unchanged; flush and stall together → bubble.
- alu_src=1, imm=0xFFFFFFFC, sw rt forwarded 0xAB → operandB=0xFFFFFFFC, ex_store_data=0xAB.

Source files
------------

// File: rtl/id_ex_issue.sv
// rtl/id_ex_issue.sv - ID/EX issue register with RAW forwarding, load-use bubble, hold and flush.
// Optional forwarding is enabled by defining ID_EX_FORWARD_EN; otherwise RAW hazards stall instead.
module id_ex_issue #(
  parameter int WIDTH   = 32,
  parameter int REGBITS = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               flush,
  input  logic               id_valid,
  input  logic [REGBITS-1:0] id_rs,
  input  logic [REGBITS-1:0] id_rt,
  input  logic [REGBITS-1:0] id_rd,
  input  logic [WIDTH-1:0]   id_rs_data,
  input  logic [WIDTH-1:0]   id_rt_data,
  input  logic [WIDTH-1:0]   id_imm,
  input  logic [3:0]         id_alu_op,
  input  logic [5:0]         id_ctrl,
  input  logic               exmem_reg_write,
  input  logic [REGBITS-1:0] exmem_rd,
  input  logic [WIDTH-1:0]   exmem_result,
  input  logic               memwb_reg_write,
  input  logic [REGBITS-1:0] memwb_rd,
  input  logic [WIDTH-1:0]   memwb_data,
  output logic               hazard_stall,
  output logic               ex_valid,
  output logic [WIDTH-1:0]   operandA,
  output logic [WIDTH-1:0]   operandB,
  output logic [3:0]         operation,
  output logic [WIDTH-1:0]   ex_store_data,
  output logic [REGBITS-1:0] ex_rd,
  output logic [3:0]         ex_ctrl
);

  logic               valid_q;
  logic [REGBITS-1:0] rs_q;
  logic [REGBITS-1:0] rt_q;
  logic [REGBITS-1:0] rd_q;
  logic [WIDTH-1:0]   rs_data_q;
  logic [WIDTH-1:0]   rt_data_q;
  logic [WIDTH-1:0]   imm_q;
  logic [3:0]         alu_op_q;
  logic [5:0]         ctrl_q;

  logic [WIDTH-1:0]   fwd_a;
  logic [WIDTH-1:0]   fwd_b;

  // Does the decode instruction read register r (r nonzero)?
  logic               id_reads_ex_rd;
  logic               load_use;

  assign id_reads_ex_rd = (rd_q != '0) &&
                          ((rd_q == id_rs) || (id_ctrl[0] && (rd_q == id_rt)));
  assign load_use = id_valid && valid_q && ctrl_q[4] && id_reads_ex_rd;

`ifdef ID_EX_FORWARD_EN
  assign hazard_stall = load_use;

  always_comb begin
    fwd_a = rs_data_q;
    if (exmem_reg_write && (exmem_rd == rs_q) && (rs_q != '0)) begin
      fwd_a = exmem_result;
    end else if (memwb_reg_write && (memwb_rd == rs_q) && (rs_q != '0)) begin
      fwd_a = memwb_data;
    end
  end

  always_comb begin
    fwd_b = rt_data_q;
    if (exmem_reg_write && (exmem_rd == rt_q) && (rt_q != '0)) begin
      fwd_b = exmem_result;
    end else if (memwb_reg_write && (memwb_rd == rt_q) && (rt_q != '0)) begin
      fwd_b = memwb_data;
    end
  end

  logic unused_bits;
  assign unused_bits = ctrl_q[0];
`else
  // Without bypass paths, any producer still ahead of writeback must drain first.
  logic id_reads_exmem_rd;
  logic raw_ex;
  logic raw_exmem;

  assign id_reads_exmem_rd = (exmem_rd != '0) &&
                             ((exmem_rd == id_rs) || (id_ctrl[0] && (exmem_rd == id_rt)));
  assign raw_ex       = id_valid && valid_q && ctrl_q[5] && id_reads_ex_rd;
  assign raw_exmem    = id_valid && exmem_reg_write && id_reads_exmem_rd;
  assign hazard_stall = load_use || raw_ex || raw_exmem;

  assign fwd_a = rs_data_q;
  assign fwd_b = rt_data_q;

  logic unused_bits;
  assign unused_bits = ^{ctrl_q[0], rs_q, rt_q, exmem_result,
                         memwb_reg_write, memwb_rd, memwb_data};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q   <= 1'b0;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      alu_op_q  <= '0;
      ctrl_q    <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
    end else if (stall) begin
      valid_q <= valid_q;
    end else if (hazard_stall) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
    end else begin
      valid_q   <= id_valid;
      rs_q      <= id_rs;
      rt_q      <= id_rt;
      rd_q      <= id_rd;
      rs_data_q <= id_rs_data;
      rt_data_q <= id_rt_data;
      imm_q     <= id_imm;
      alu_op_q  <= id_alu_op;
      ctrl_q    <= id_valid ? id_ctrl : 6'b0;
    end
  end

  assign ex_valid      = valid_q;
  assign operandA      = fwd_a;
  assign operandB      = ctrl_q[1] ? imm_q : fwd_b;
  assign ex_store_data = fwd_b;
  assign operation     = alu_op_q;
  assign ex_rd         = rd_q;
  assign ex_ctrl       = valid_q ? ctrl_q[5:2] : 4'b0;

endmodule
